alp_op_scheduler: RTL

ALP_OP_SCHEDULER -- requirements
Module: alp_op_scheduler

---
 rtl/alp_pkg.sv | 48 ++++
 rtl/alp_rr_arb2.sv | 22 ++
 rtl/alp_op_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alp_pkg.sv
// Shared definitions for the ALP operation scheduler: op codes, command
// encodings, latency table and the scheduler FSM state type.
package alp_pkg;

  // ALU op codes
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MUL    = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;
  localparam logic [2:0] OP_BITCLR = 3'b111;

  // Command encodings
  localparam logic [1:0] CMD_COMP = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_CLR  = 2'b10;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  // Wait-cycle latencies
  localparam int unsigned LAT_SIMPLE = 2;
  localparam int unsigned LAT_MUL    = 14;
  localparam int unsigned LAT_DIV    = 20;
  localparam int unsigned LAT_ILL    = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } alp_state_e;

  // Latency lookup: only compute-mode mul/div are long; load/clear are simple
  // whatever op code rides along; an illegal command spends one wait cycle.
  function automatic int unsigned lat_of(input logic [2:0] op, input logic [1:0] cmd);
    int unsigned lat;
    lat = LAT_SIMPLE;
    if (cmd == CMD_ILL) begin
      lat = LAT_ILL;
    end else if (cmd == CMD_COMP) begin
      if (op == OP_MUL) lat = LAT_MUL;
      else if (op == OP_DIV) lat = LAT_DIV;
    end
    return lat;
  endfunction

endpackage

// File: rtl/alp_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that did not win last time is chosen. Output is one-hot or zero.
module alp_rr_arb2
  import alp_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Grant selection from the current requests and the previous winner
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alp_op_scheduler.sv
// Schedules ALU operations from two requesters onto a single processor
// controller. One operation is in flight at a time:
//   IDLE -> ISSUE -> WAIT (latency cycles) -> DONE -> IDLE
// Handshake: a requester holds req_valid (with stable op/cmd) until it sees
// its req_ready bit; the transfer happens on the rising edge where both are
// high. req_ready is only ever raised in IDLE and for at most one index.
module alp_op_scheduler
  import alp_pkg::*;
#(
  parameter int LAT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [2:0] req_op0,
  input  logic [2:0] req_op1,
  input  logic [1:0] req_cmd0,
  input  logic [1:0] req_cmd1,
  output logic [2:0] alp_op,
  output logic       alp_comp,
  output logic       alp_load,
  output logic       alp_clr,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       err,
  output logic [1:0] dbg_state_o
);

  alp_state_e       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             id_q, id_d;
  // Grants are held off for the first cycle after reset is released.
  logic             en_q;
  logic [1:0]       grant;

  alp_rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign dbg_state_o = state_q;

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    op_d      = op_q;
    cmd_d     = cmd_q;
    id_d      = id_q;
    req_ready = 2'b00;
    alp_op    = 3'b000;
    alp_comp  = 1'b0;
    alp_load  = 1'b0;
    alp_clr   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    done_id   = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q && (grant != 2'b00)) begin
          req_ready = grant;
          id_d      = grant[1];
          last_d    = grant[1];
          op_d      = grant[1] ? req_op1 : req_op0;
          cmd_d     = grant[1] ? req_cmd1 : req_cmd0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy     = 1'b1;
        alp_op   = op_q;
        alp_comp = (cmd_q == CMD_COMP);
        alp_load = (cmd_q == CMD_LOAD);
        alp_clr  = (cmd_q == CMD_CLR);
        cnt_d    = LAT_W'(lat_of(op_q, cmd_q));
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        busy   = 1'b1;
        alp_op = op_q;
        // Leave on the cycle the counter shows 1; treat 0 the same so a
        // corrupted count can never stall or wrap.
        if (cnt_q <= LAT_W'(1)) state_d = ST_DONE;
        if (cnt_q != '0) cnt_d = cnt_q - LAT_W'(1);
      end
      ST_DONE: begin
        busy    = 1'b1;
        alp_op  = op_q;
        done    = 1'b1;
        done_id = id_q;
        err     = (cmd_q == CMD_ILL);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      op_q    <= 3'b000;
      cmd_q   <= 2'b00;
      id_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      cmd_q   <= cmd_d;
      id_q    <= id_d;
      en_q    <= 1'b1;
    end
  end

endmodule
